ch_readout_sequencer: RTL and testbench

Per-channel readout sequencer that runs once the channel sampling state machine reaches the readout state. It takes the start mode and the trigger count captured during sampling, and computes how many sample banks (A–E) hold valid data. It then walks those banks in order, emitting one bank/address beat per sample over a valid/ready handshake to the downstream sample-memory/serializer path. It inserts a programmable settle gap before each bank, and it supports abort and error reporting.

---
 rtl/ch_readout_sequencer.sv | 125 ++++++++++++
 tb/tb_ch_readout_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ch_readout_sequencer.sv
// Per-channel readout sequencer: sizes the bank walk from start mode and trigger
// count, then streams bank/address beats with a settle gap before each bank.
module ch_readout_sequencer #(
    parameter int NUM_SAMPLES = 256,
    parameter int ADDR_W      = 8,
    parameter int BANK_GAP    = 4
) (
    input  logic              FCLK,
    input  logic              RSTB,
    input  logic              readout_start,
    input  logic [2:0]        start_mode,
    input  logic [2:0]        trig_cnt,
    input  logic              abort,
    input  logic              rd_ready,
    output logic              rd_valid,
    output logic [2:0]        rd_bank,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_last,
    output logic              busy,
    output logic              done,
    output logic              err
);
    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_GAP, S_STREAM, S_DONE} state_t;

    localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(NUM_SAMPLES - 1);
    localparam int                GAP_W      = (BANK_GAP > 2) ? $clog2(BANK_GAP) : 1;
    localparam int                GAP_LAST_I = (BANK_GAP > 0) ? BANK_GAP - 1 : 0;
    localparam logic [GAP_W-1:0]  GAP_LAST   = GAP_W'(GAP_LAST_I);
    localparam state_t            S_BANK_IN  = (BANK_GAP == 0) ? S_STREAM : S_GAP;

    state_t            r_state, w_next;
    logic [2:0]        r_mode, r_tc, r_bank;
    logic [3:0]        r_nbanks;
    logic [ADDR_W-1:0] r_addr;
    logic [GAP_W-1:0]  r_gap;
    logic              r_err;

    logic [2:0] w_win, w_tc;
    logic [4:0] w_prod;
    logic       w_onehot, w_xfer, w_addr_last, w_bank_last;

    always_comb begin
        w_win = 3'd0;
        case (r_mode)
            3'b001:  w_win = 3'd1;
            3'b010:  w_win = 3'd2;
            3'b100:  w_win = 3'd4;
            default: w_win = 3'd0;
        endcase
    end

    // Product fits 5 bits (max 4*5), capped to 5 banks before storing.
    assign w_onehot    = (w_win != 3'd0);
    assign w_tc        = (r_tc > 3'd4) ? 3'd4 : r_tc;
    assign w_prod      = 5'(w_win) * (5'(w_tc) + 5'd1);
    assign w_xfer      = (r_state == S_STREAM) && rd_ready;
    assign w_addr_last = (r_addr == ADDR_LAST);
    assign w_bank_last = ({1'b0, r_bank} == (r_nbanks - 4'd1));

    always_ff @(posedge FCLK or negedge RSTB) begin
        if (!RSTB) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (readout_start) w_next = S_SETUP;
            S_SETUP:  w_next = w_onehot ? S_BANK_IN : S_IDLE;
            S_GAP:    if (r_gap == GAP_LAST) w_next = S_STREAM;
            S_STREAM: if (w_xfer && w_addr_last) w_next = w_bank_last ? S_DONE : S_BANK_IN;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
        // Abort wins over everything, even the final transfer.
        if (abort && r_state != S_IDLE) w_next = S_IDLE;
    end

    always_comb begin
        rd_valid = (r_state == S_STREAM);
        busy     = (r_state != S_IDLE);
        done     = (r_state == S_DONE);
        rd_last  = rd_valid && w_addr_last && w_bank_last;
        rd_bank  = r_bank;
        rd_addr  = r_addr;
        err      = r_err;
    end

    always_ff @(posedge FCLK or negedge RSTB) begin
        if (!RSTB) begin
            r_mode   <= '0;
            r_tc     <= '0;
            r_nbanks <= '0;
            r_bank   <= '0;
            r_addr   <= '0;
            r_gap    <= '0;
            r_err    <= 1'b0;
        end else begin
            r_err <= (r_state == S_SETUP) && !abort && !w_onehot;
            case (r_state)
                S_IDLE: if (readout_start) begin
                    r_mode <= start_mode;
                    r_tc   <= trig_cnt;
                end
                S_SETUP: begin
                    r_nbanks <= (w_prod > 5'd5) ? 4'd5 : w_prod[3:0];
                    r_bank   <= '0;
                    r_addr   <= '0;
                    r_gap    <= '0;
                end
                S_GAP: r_gap <= (r_gap == GAP_LAST) ? '0 : r_gap + GAP_W'(1);
                S_STREAM: if (w_xfer) begin
                    if (!w_addr_last) begin
                        r_addr <= r_addr + ADDR_W'(1);
                    end else if (!w_bank_last) begin
                        r_bank <= r_bank + 3'd1;
                        r_addr <= '0;
                        r_gap  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ch_readout_sequencer.sv
// Bench for ch_readout_sequencer: vector table of readout runs plus hand-built
// abort, ignored-start and mid-stream reset sequences; beats scored from a queue.
module tb_ch_readout_sequencer;
    localparam int NS  = 4;
    localparam int AW  = 2;
    localparam int GAP = 2;

    logic          FCLK = 0, RSTB = 0, readout_start = 0, abort = 0, rd_ready = 0;
    logic [2:0]    start_mode = 0, trig_cnt = 0;
    logic          rd_valid, rd_last, busy, done, err;
    logic [2:0]    rd_bank;
    logic [AW-1:0] rd_addr;

    ch_readout_sequencer #(.NUM_SAMPLES(NS), .ADDR_W(AW), .BANK_GAP(GAP)) dut (
        .FCLK(FCLK), .RSTB(RSTB), .readout_start(readout_start), .start_mode(start_mode),
        .trig_cnt(trig_cnt), .abort(abort), .rd_ready(rd_ready), .rd_valid(rd_valid),
        .rd_bank(rd_bank), .rd_addr(rd_addr), .rd_last(rd_last), .busy(busy),
        .done(done), .err(err)
    );

    always #5 FCLK = ~FCLK;

    int nchk = 0, nerr = 0;

    typedef struct {logic [2:0] bank; logic [AW-1:0] addr; logic last;} beat_t;
    typedef struct {logic [2:0] mode; logic [2:0] trig; bit toggle; int nbanks; bit err;} vec_t;

    beat_t exp_q[$];
    beat_t mon_e;
    vec_t  vecs[8];

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_beats(input int nb, input int stop_bank, input int stop_addr);
        for (int b = 0; b < nb; b++)
            for (int a = 0; a < NS; a++)
                if (b < stop_bank || (b == stop_bank && a <= stop_addr))
                    exp_q.push_back('{bank: 3'(b), addr: AW'(a), last: (b == nb-1 && a == NS-1)});
    endtask

    function automatic logic rdy(input bit tog, input int k);
        if (!tog) return 1'b1;
        case ((k - 1) % 4)
            0, 3:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic outs_zero(input string tag);
        chk({tag, "_valid"}, rd_valid, 0);
        chk({tag, "_bank"}, rd_bank, 0);
        chk({tag, "_addr"}, rd_addr, 0);
        chk({tag, "_last"}, rd_last, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    // Monitor: scores transfers and checks outputs hold while stalled.
    logic          stall_p = 0, abort_p = 0;
    logic [2:0]    bank_p = 0;
    logic [AW-1:0] addr_p = 0;
    always @(negedge FCLK) begin
        if (!RSTB) begin
            stall_p = 0;
        end else begin
            if (stall_p && !abort_p) begin
                chk("hold_valid", rd_valid, 1);
                chk("hold_bank", rd_bank, bank_p);
                chk("hold_addr", rd_addr, addr_p);
            end
            if (rd_valid && rd_ready) begin
                nchk++;
                if (exp_q.size() == 0) begin
                    nerr++;
                    $display("FAIL extra_beat: got bank %0d addr %0d, expected no beat", rd_bank, rd_addr);
                end else begin
                    nchk--;
                    mon_e = exp_q.pop_front();
                    chk("beat_bank", rd_bank, mon_e.bank);
                    chk("beat_addr", rd_addr, mon_e.addr);
                    chk("beat_last", rd_last, mon_e.last);
                end
            end
            stall_p = rd_valid && !rd_ready;
            bank_p  = rd_bank;
            addr_p  = rd_addr;
            abort_p = abort;
        end
    end

    task automatic pulse_start(input logic [2:0] m, input logic [2:0] t);
        start_mode    = m;
        trig_cnt      = t;
        readout_start = 1;
        @(posedge FCLK); #1;
        readout_start = 0;
    endtask

    task automatic wait_valid(input string tag);
        int k;
        for (k = 0; k < 50 && !rd_valid; k++) @(negedge FCLK);
        chk({tag, "_valid_seen"}, rd_valid, 1);
    endtask

    task automatic run_seq(input vec_t v);
        int first_v, last_x, done_k, nd, ne, prev_vk;
        bit fin;
        if (!v.err) push_beats(v.nbanks, 7, NS);
        rd_ready = 1;
        pulse_start(v.mode, v.trig);
        rd_ready = rdy(v.toggle, 1);
        first_v = -1; last_x = -1; done_k = -1; nd = 0; ne = 0; prev_vk = -1; fin = 0;
        for (int k = 1; k <= 300; k++) begin
            @(negedge FCLK);
            if (k == 1) chk("busy_after_start", busy, 1);
            if (rd_valid) begin
                if (prev_vk >= 0 && prev_vk != k - 1) chk("bank_gap", k - prev_vk - 1, GAP);
                if (first_v < 0) first_v = k;
                prev_vk = k;
                if (rd_ready) last_x = k;
            end
            if (done) begin nd++; done_k = k; end
            if (err) begin ne++; chk("err_busy_low", busy, 0); end
            if (!busy && k >= 2) begin fin = 1; break; end
            @(posedge FCLK); #1;
            rd_ready = rdy(v.toggle, k + 1);
        end
        nchk++;
        if (!fin) begin nerr++; $display("FAIL seq_timeout: got busy %0d, expected idle", busy); end
        chk("err_pulses", ne, v.err);
        chk("done_pulses", nd, !v.err);
        if (!v.err) begin
            chk("first_valid_cycle", first_v, 2 + GAP);
            chk("done_after_last", done_k, last_x + 1);
        end else begin
            chk("no_valid_on_err", first_v, -1);
        end
        chk("beats_left", exp_q.size(), 0);
    endtask

    initial begin
        int nd;
        bit hit;
        vecs[0] = '{3'b001, 3'd2, 0, 3, 0};
        vecs[1] = '{3'b010, 3'd3, 0, 5, 0};
        vecs[2] = '{3'b100, 3'd0, 1, 4, 0};
        vecs[3] = '{3'b001, 3'd7, 0, 5, 0};
        vecs[4] = '{3'b011, 3'd0, 0, 0, 1};
        vecs[5] = '{3'b000, 3'd1, 0, 0, 1};
        vecs[6] = '{3'b010, 3'd0, 1, 2, 0};
        vecs[7] = '{3'b100, 3'd2, 0, 5, 0};

        #3 outs_zero("reset");
        repeat (2) @(negedge FCLK);
        RSTB = 1;
        @(negedge FCLK);

        foreach (vecs[i]) run_seq(vecs[i]);

        // Abort at bank 2 addr 1; that beat still transfers.
        push_beats(5, 2, 1);
        exp_q[exp_q.size() - 1].last = 0;
        rd_ready = 1;
        pulse_start(3'b001, 3'd7);
        hit = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge FCLK);
            if (rd_valid && rd_bank == 2 && rd_addr == 1) begin
                abort = 1;
                @(posedge FCLK); #1;
                abort = 0;
                hit = 1;
                break;
            end
        end
        chk("abort_point_seen", hit, 1);
        @(negedge FCLK);
        chk("abort_valid", rd_valid, 0);
        chk("abort_busy", busy, 0);
        nd = 0;
        repeat (6) begin @(negedge FCLK); if (done || busy) nd++; end
        chk("abort_quiet", nd, 0);
        chk("abort_beats_left", exp_q.size(), 0);

        // A start request during STREAM must be ignored.
        push_beats(1, 7, NS);
        rd_ready = 0;
        pulse_start(3'b001, 3'd0);
        wait_valid("ign");
        pulse_start(3'b100, 3'd4);
        rd_ready = 1;
        nd = 0;
        repeat (30) begin @(negedge FCLK); if (done) nd++; end
        chk("ign_done", nd, 1);
        chk("ign_beats_left", exp_q.size(), 0);
        chk("ign_idle", busy, 0);

        // Reset mid-STREAM then a fresh single-bank run.
        rd_ready = 0;
        pulse_start(3'b100, 3'd2);
        wait_valid("rst");
        #2 RSTB = 0;
        #1 outs_zero("midrst");
        repeat (2) @(negedge FCLK);
        RSTB = 1;
        nd = 0;
        repeat (4) begin @(negedge FCLK); if (done || busy) nd++; end
        chk("post_rst_quiet", nd, 0);
        run_seq('{3'b001, 3'd0, 0, 1, 0});

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
